polyq_load_ctrl: RTL and testbench
==================================

// Module: polyq_load_ctrl
// PURPOSE
//   Loads a p-coefficient polynomial into the polyQ memory after it is cleared. On start it pulses
//   clr_start to the polyQ clear FSM and waits for clr_done (its write_done). It then accepts a
//   valid/ready coefficient stream, freezes each coefficient to [0,Q) and writes addresses 0..P-1.
//   Downstream of the clear FSM; feeds the Zq polynomial multiplier datapath.
// PARAMETERS
//   P   761   polynomial length (coefficients written per load)
//   Q   4591  modulus; stored coefficients are in [0,Q)
//   AW  11    memory address width; also the width of the coefficient counter
//   DW  13    stored coefficient width
//   IW  14    input coefficient width; input is unsigned and must be in [0,2Q)
// PORTS
//   clk        in   1   rising-edge clock; single clock domain
//   rst_n      in   1   synchronous, active-low reset
//   start      in   1   level; sampled only in IDLE
//   clr_start  out  1   one-cycle pulse to the polyQ clear FSM start input
//   clr_done   in   1   clear FSM write_done; sampled only in WAIT_CLR
//   s_valid    in   1   input coefficient valid
//   s_ready    out  1   high only in LOAD
//   s_data     in   IW  input coefficient
//   mem_we     out  1   memory write enable (registered)
//   mem_addr   out  AW  write address (registered)
//   mem_wdata  out  DW  frozen coefficient (registered)
//   busy       out  1   high in every state except IDLE
//   done       out  1   one-cycle pulse when the last write issues
//   err        out  1   sticky; set when any s_data >= 2Q; cleared when a new load is accepted
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge):
//   - state=IDLE, counter=0.
//   - All outputs 0: clr_start, s_ready, mem_we, mem_addr, mem_wdata, busy, done, err.
//   - Reset mid-load abandons the load; the memory keeps a partial polynomial.
// STATES
//   IDLE    : start=1 -> CLR; clr_start=1 on the next cycle; err cleared; counter=0.
//   CLR     : one cycle with clr_start=1 -> WAIT_CLR.
//   WAIT_CLR: clr_done=1 -> LOAD; otherwise stay. Waits indefinitely; there is no timeout.
//   LOAD    : s_ready=1. Each cycle with s_valid&s_ready is an accept.
//             - Accept with counter<P-1: counter+1.
//             - Accept with counter==P-1 -> FIN.
//   FIN     : s_ready=0; -> IDLE on the next cycle.
// WRITE PATH
//   - Write latency: 1 cycle. The cycle after an accept, mem_we=1, mem_addr=counter_at_accept and
//     mem_wdata=freeze(s_data). mem_we=0 in all other cycles.
//   - freeze(x): x<Q -> x; Q<=x<2Q -> x-Q; x>=2Q -> 0, and err is set.
//   - Subtraction is done at IW bits and the result is truncated to DW. mem_addr never exceeds P-1.
//   - done pulses in the same cycle as the write to address P-1, i.e. while in FIN.
// BOUNDARY CASES
//   - start held or re-asserted while busy: ignored. A new load needs IDLE.
//   - clr_done seen outside WAIT_CLR: ignored.
//   - s_valid outside LOAD: not accepted (s_ready=0). The upstream must hold the data.
//   - s_valid gaps in LOAD: counter holds, no write.
//   - Back-to-back accepts: one write per cycle; P accepts complete in P cycles.
//   - start still high on the FIN->IDLE cycle: a new load begins on the next IDLE cycle.
// STRUCTURE
//   - Shared package polyq_pkg: P, Q, AW, DW, IW constants and the 3-bit state typedef/encoding
//     (IDLE, CLR, WAIT_CLR, LOAD, FIN). The clear FSM and the multiplier use the same package.
//   - One sub-module, zq_freeze: combinational conditional subtract, IW in, DW out plus an
//     out_of_range flag. Instantiate it in front of the mem_wdata register.
// TESTING
//   T1 Reset: rst_n=0 for 2 cycles during LOAD at counter=100 -> all outputs 0, state IDLE,
//      and no mem_we after release.
//   T2 Full load: start; clr_done 5 cycles after clr_start; 761 back-to-back values k=0..760
//      -> 761 writes, addr k = data k; done at addr 760; busy falls the next cycle.
//   T3 Freeze: values 0, 4590, 4591, 9181, 9182 -> wdata 0, 4590, 0, 4590, 0; err=1 after the
//      5th value; err stays set until the next load starts.
//   T4 Handshake gaps: random s_valid (50%), s_valid high during WAIT_CLR -> no accept before
//      LOAD; addresses contiguous 0..760; data order preserved.
//   T5 Ignored events: start pulsed during LOAD, clr_done pulsed in IDLE and LOAD
//      -> no extra clr_start, counter unaffected.
//   T6 Restart: start held high through done -> second clr_start one cycle after the return to
//      IDLE; the second load writes from addr 0.

Source files
------------

// File: rtl/polyq_pkg.sv
// Shared constants and FSM state encoding for the polyQ memory controllers
// (clear FSM, load controller, Zq multiplier datapath).
package polyq_pkg;

    localparam int P  = 761;
    localparam int Q  = 4591;
    localparam int AW = 11;
    localparam int DW = 13;
    localparam int IW = 14;

    localparam logic [AW-1:0] LAST_ADDR = AW'(P - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR      = 3'd1,
        ST_WAIT_CLR = 3'd2,
        ST_LOAD     = 3'd3,
        ST_FIN      = 3'd4
    } state_t;

endpackage

// File: rtl/zq_freeze.sv
// Maps an input in [0,2Q) to [0,Q) by one conditional subtraction;
// anything at or above 2Q is forced to 0 and flagged.
module zq_freeze
    import polyq_pkg::*;
(
    input  logic [IW-1:0] x_i,
    output logic [DW-1:0] y_o,
    output logic          oor_o
);

    localparam logic [IW-1:0] Q_IW  = IW'(Q);
    localparam logic [IW-1:0] Q2_IW = IW'(2 * Q);

    always_comb begin
        y_o   = '0;
        oor_o = 1'b0;
        if (x_i >= Q2_IW) begin
            oor_o = 1'b1;
        end else if (x_i >= Q_IW) begin
            y_o = DW'(x_i - Q_IW);
        end else begin
            y_o = DW'(x_i);
        end
    end

endmodule

// File: rtl/polyq_load_ctrl.sv
// Clears the polyQ memory through the clear FSM, then streams P frozen
// coefficients into addresses 0..P-1 with a one-cycle registered write.
module polyq_load_ctrl
    import polyq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          clr_start,
    input  logic          clr_done,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [IW-1:0] s_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;
    logic          clr_start_q;
    logic          s_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    logic          accept;
    logic [DW-1:0] frz_data;
    logic          frz_oor;

    zq_freeze u_freeze (
        .x_i   (s_data),
        .y_o   (frz_data),
        .oor_o (frz_oor)
    );

    assign accept = s_valid & s_ready_q;
    assign cnt_d  = cnt_q + AW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clr_start_q <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Write path: the accepted beat lands in memory one cycle later.
            mem_we_q <= accept;
            if (accept) begin
                mem_addr_q  <= cnt_q;
                mem_wdata_q <= frz_data;
                if (frz_oor) begin
                    err_q <= 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_CLR;
                        clr_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                ST_CLR: begin
                    state_q     <= ST_WAIT_CLR;
                    clr_start_q <= 1'b0;
                end
                ST_WAIT_CLR: begin
                    if (clr_done) begin
                        state_q   <= ST_LOAD;
                        s_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (cnt_q == LAST_ADDR) begin
                            state_q   <= ST_FIN;
                            s_ready_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    clr_start_q <= 1'b0;
                    s_ready_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign clr_start = clr_start_q;
    assign s_ready   = s_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_polyq_load_ctrl.sv
// Testbench for polyq_load_ctrl: phase-level stimulus with a write scoreboard
// and a modulo-based freeze reference.
module tb_polyq_load_ctrl;
    import polyq_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          clr_start;
    logic          clr_done;
    logic          s_valid;
    logic          s_ready;
    logic [IW-1:0] s_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    polyq_load_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clr_start (clr_start),
        .clr_done  (clr_done),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;
    wr_t exp_q[$];
    bit  mon_en = 1'b0;

    typedef struct {
        logic [IW-1:0] din;
        logic [DW-1:0] wdata;
        logic          err_after;
    } vec_t;
    vec_t tab[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reduce mod Q when in [0,2Q), otherwise 0.
    function automatic int freeze_ref(input int x);
        if (x >= 2 * Q) return 0;
        return x % Q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_clr_start"}, clr_start, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Write scoreboard: every write must match the next accepted beat, in order.
    always @(negedge clk) begin : mon
        wr_t w;
        if (mon_en) begin
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", int'(mem_addr), w.addr);
                    chk("wr_data", int'(mem_wdata), w.data);
                    chk("done_at_last", int'(done), int'(w.addr == P - 1));
                end
            end else begin
                chk("done_without_write", int'(done), 0);
            end
        end
    end

    // One load: clear handshake, then P accepts. dmode 0: data=k, 1: random, 2: table then random.
    task automatic do_load(input int clr_delay, input int vpct, input int dmode,
                           input bit hold, input bit noise, input int abort_at);
        int            cnt;
        int            cyc;
        int            tab_pend;
        bit            exp_err;
        bit            v;
        int            r;
        int            ev;
        logic [IW-1:0] d;
        wr_t           w;

        exp_err = 1'b0;
        chk("pre_busy", busy, 0);
        start = 1'b1;
        tick();
        chk("clr_start_pulse", clr_start, 1);
        chk("busy_clr", busy, 1);
        chk("err_cleared", err, 0);
        chk("ready_clr", s_ready, 0);
        if (!hold) start = 1'b0;

        for (int i = 0; i <= clr_delay; i++) begin
            if (noise) begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = IW'($urandom_range(0, 2 * Q - 1));
                start   = 1'($urandom_range(0, 1));
            end
            clr_done = (i == clr_delay);
            tick();
            if (i < clr_delay) begin
                chk("clr_start_once", clr_start, 0);
                chk("ready_wait", s_ready, 0);
                chk("busy_wait", busy, 1);
            end
        end
        clr_done = 1'b0;
        s_valid  = 1'b0;
        start    = hold;

        cnt      = 0;
        cyc      = 0;
        tab_pend = -1;
        while (cnt < P) begin
            chk("ready_load", s_ready, 1);
            chk("busy_load", busy, 1);
            chk("clr_start_load", clr_start, 0);
            if (tab_pend >= 0) begin
                chk("tab_err", err, int'(tab[tab_pend].err_after));
                tab_pend = -1;
            end
            if (abort_at == cnt) break;
            v = ($urandom_range(0, 99) < vpct);
            if (dmode == 0) begin
                d  = IW'(cnt);
                ev = cnt;
            end else if (dmode == 2 && cnt < 5) begin
                d  = tab[cnt].din;
                ev = int'(tab[cnt].wdata);
            end else begin
                r = $urandom_range(0, 63);
                if (r == 0) d = IW'($urandom_range(2 * Q, (1 << IW) - 1));
                else        d = IW'($urandom_range(0, 2 * Q - 1));
                ev = freeze_ref(int'(d));
            end
            s_valid = v;
            s_data  = d;
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                clr_done = 1'($urandom_range(0, 1));
            end
            if (v) begin
                w.addr = cnt;
                w.data = ev;
                exp_q.push_back(w);
                if (int'(d) >= 2 * Q) exp_err = 1'b1;
                if (dmode == 2 && cnt < 5) tab_pend = cnt;
                cnt++;
            end
            tick();
            cyc++;
            if (cyc > 20000) begin
                chk("load_timeout", cnt, P);
                break;
            end
        end

        if (abort_at >= 0 && cnt == abort_at) begin
            start    = 1'b0;
            clr_done = 1'b0;
            s_valid  = 1'b1;
            s_data   = IW'(5);
            rst_n    = 1'b0;
            tick();
            chk_all_zero("abort_rst1");
            tick();
            chk_all_zero("abort_rst2");
            chk("abort_pending", exp_q.size(), 0);
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("post_abort_we", mem_we, 0);
                chk("post_abort_busy", busy, 0);
                chk("post_abort_ready", s_ready, 0);
            end
            s_valid = 1'b0;
            return;
        end

        s_valid  = 1'b0;
        clr_done = 1'b0;
        start    = hold;
        chk("fin_done", done, 1);
        chk("fin_ready", s_ready, 0);
        chk("fin_busy", busy, 1);
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_clr_start", clr_start, 0);
        chk("err_final", err, int'(exp_err));
        chk("all_written", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{din: 14'd0,    wdata: 13'd0,    err_after: 1'b0};
        tab[1] = '{din: 14'd4590, wdata: 13'd4590, err_after: 1'b0};
        tab[2] = '{din: 14'd4591, wdata: 13'd0,    err_after: 1'b0};
        tab[3] = '{din: 14'd9181, wdata: 13'd4590, err_after: 1'b0};
        tab[4] = '{din: 14'd9182, wdata: 13'd0,    err_after: 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        clr_done = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Reset mid-load at counter 100
        do_load(3, 100, 1, 1'b0, 1'b0, 100);

        // Full back-to-back load, clr_done 5 cycles after clr_start
        do_load(5, 100, 0, 1'b0, 1'b0, -1);

        // Freeze vectors, then err must persist through IDLE with stray clr_done
        do_load(2, 100, 2, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin
            clr_done = (i == 1);
            tick();
            chk("idle_err_sticky", err, 1);
            chk("idle_clr_done_busy", busy, 0);
            chk("idle_clr_done_clr_start", clr_start, 0);
        end
        clr_done = 1'b0;

        // Gappy stream with stray start/clr_done/s_valid
        do_load(int'($urandom_range(1, 8)), 50, 1, 1'b0, 1'b1, -1);
        do_load(int'($urandom_range(1, 8)), 50, 1, 1'b0, 1'b1, -1);

        // start held through done: restart right after the return to IDLE
        do_load(1, 100, 1, 1'b1, 1'b0, -1);
        do_load(4, 100, 1, 1'b0, 1'b0, -1);

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
